// File: rtl/prbs_checker.sv
// PRBS-8 receive checker (x^8+x^4+x^3+x^2+1, Galois generator, stage-7 output).
// Hunts for lock on the incoming serial stream, then flywheels on its own
// prediction and counts bit errors. Sampling is qualified by bit_en.
module prbs_checker #(
    parameter int LOCK_MATCHES = 16,
    parameter int WIN_LEN      = 64,
    parameter int LOSS_ERRS    = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             prbs_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int MC_W = $clog2(LOCK_MATCHES + 1);
    localparam int WB_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WE_W = $clog2(LOSS_ERRS + 1);

    localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(LOCK_MATCHES - 1);
    localparam logic [MC_W-1:0]  MC_ONE     = MC_W'(1);
    localparam logic [WB_W-1:0]  WIN_LAST   = WB_W'(WIN_LEN - 1);
    localparam logic [WB_W-1:0]  WB_ONE     = WB_W'(1);
    localparam logic [WE_W-1:0]  LOSS_LAST  = WE_W'(LOSS_ERRS - 1);
    localparam logic [WE_W-1:0]  WE_ONE     = WE_W'(1);
    localparam logic [3:0]       FILL_DONE  = 4'd8;
    localparam logic [3:0]       FILL_ONE   = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       h, h_nxt;
    logic [3:0]       fill, fill_nxt;
    logic [MC_W-1:0]  match_cnt, match_nxt;
    logic [WB_W-1:0]  win_bit, win_bit_nxt;
    logic [WE_W-1:0]  win_err, win_err_nxt;
    logic [WE_W-1:0]  win_err_base;
    logic             locked_nxt;
    logic             err_pulse_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic [CNT_W-1:0] bit_count_nxt;
    logic [CNT_W-1:0] err_count_inc;
    logic [CNT_W-1:0] bit_count_inc;

    logic pred;
    logic mismatch;
    logic hunt_match;

    // o[n] = o[n-4]^o[n-5]^o[n-6]^o[n-8] with h[0] the newest bit
    assign pred       = h[3] ^ h[4] ^ h[5] ^ h[7];
    assign mismatch   = prbs_in ^ pred;
    // an all-zero history followed by a zero is the stuck-at-0 line, never a match
    assign hunt_match = !mismatch && !((h == '0) && !prbs_in);

    // Saturating increments of the statistics counters
    always_comb begin
        err_count_inc = (err_count == '1) ? err_count : err_count + CNT_ONE;
        bit_count_inc = (bit_count == '1) ? bit_count : bit_count + CNT_ONE;
    end

    // Next-state and next-output logic for the hunt/flywheel FSM
    always_comb begin
        state_nxt     = state;
        h_nxt         = h;
        fill_nxt      = fill;
        match_nxt     = match_cnt;
        win_bit_nxt   = win_bit;
        win_err_nxt   = win_err;
        win_err_base  = '0;
        locked_nxt    = locked;
        err_pulse_nxt = 1'b0;
        err_count_nxt = err_count;
        bit_count_nxt = bit_count;

        if (bit_en) begin
            case (state)
                HUNT: begin
                    h_nxt = {h[6:0], prbs_in};
                    if (fill != FILL_DONE) begin
                        fill_nxt = fill + FILL_ONE;
                    end else if (hunt_match) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt   = LOCKED;
                            locked_nxt  = 1'b1;
                            match_nxt   = '0;
                            win_bit_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + MC_ONE;
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end

                LOCKED: begin
                    // flywheel: the prediction, not the line, feeds the history
                    h_nxt         = {h[6:0], pred};
                    bit_count_nxt = bit_count_inc;

                    // the bit that wraps the window counter starts the next window
                    if (win_bit == WIN_LAST) begin
                        win_bit_nxt  = '0;
                        win_err_base = '0;
                    end else begin
                        win_bit_nxt  = win_bit + WB_ONE;
                        win_err_base = win_err;
                    end
                    win_err_nxt = win_err_base;

                    if (mismatch) begin
                        err_count_nxt = err_count_inc;
                        err_pulse_nxt = 1'b1;
                        if (win_err_base == LOSS_LAST) begin
                            state_nxt   = HUNT;
                            locked_nxt  = 1'b0;
                            fill_nxt    = '0;
                            match_nxt   = '0;
                            win_bit_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            win_err_nxt = win_err_base + WE_ONE;
                        end
                    end
                end

                default: begin
                    state_nxt  = HUNT;
                    locked_nxt = 1'b0;
                    fill_nxt   = '0;
                    match_nxt  = '0;
                end
            endcase
        end

        if (clear) begin
            err_count_nxt = '0;
            bit_count_nxt = '0;
        end
    end

    // State, history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            h         <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_bit   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            fill      <= fill_nxt;
            match_cnt <= match_nxt;
            win_bit   <= win_bit_nxt;
            win_err   <= win_err_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err_count <= err_count_nxt;
            bit_count <= bit_count_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a Galois generator model drives the line,
// a recurrence-level reference model predicts every response.
module tb_prbs_checker;

    localparam int LOCK_MATCHES = 16;
    localparam int WIN_LEN      = 64;
    localparam int LOSS_ERRS    = 8;
    localparam int CNT_W        = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_en;
    logic             prbs_in;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .WIN_LEN      (WIN_LEN),
        .LOSS_ERRS    (LOSS_ERRS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .prbs_in   (prbs_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    typedef struct {
        logic             locked;
        logic             err_pulse;
        logic [CNT_W-1:0] errs;
        logic [CNT_W-1:0] bits;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Galois generator, x^8+x^4+x^3+x^2+1, output from stage 7
    logic [7:0] gen_s;
    function automatic logic gen_next();
        logic o;
        o     = gen_s[7];
        gen_s = {gen_s[6:0], 1'b0} ^ (o ? 8'h1D : 8'h00);
        return o;
    endfunction

    // Reference model: last 8 history bits, run of matches, window bookkeeping
    bit               hist[$];
    bit               m_locked;
    int               m_run;
    int               m_lock_bits;
    int               m_win_errs;
    logic [CNT_W-1:0] m_errs;
    logic [CNT_W-1:0] m_bits;

    function automatic void model_reset();
        hist.delete();
        m_locked    = 1'b0;
        m_run       = 0;
        m_lock_bits = 0;
        m_win_errs  = 0;
        m_errs      = '0;
        m_bits      = '0;
    endfunction

    function automatic bit recur_pred();
        int n;
        n = hist.size();
        return hist[n-4] ^ hist[n-5] ^ hist[n-6] ^ hist[n-8];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1;
    endfunction

    function automatic void model_step(input logic b, input logic clr);
        obs_t e;
        bit   p;
        bit   err;
        bit   all_zero;
        err = 1'b0;
        if (!m_locked) begin
            if (hist.size() >= 8) begin
                p        = recur_pred();
                all_zero = 1'b1;
                for (int i = 1; i <= 8; i++)
                    if (hist[hist.size()-i]) all_zero = 1'b0;
                if ((b == p) && !(all_zero && !b)) m_run++;
                else m_run = 0;
            end
            hist.push_back(b);
            if (m_run == LOCK_MATCHES) begin
                m_locked    = 1'b1;
                m_run       = 0;
                m_lock_bits = 0;
                m_win_errs  = 0;
            end
        end else begin
            p   = recur_pred();
            err = (b != p);
            hist.push_back(p);
            if (m_lock_bits % WIN_LEN == WIN_LEN - 1) m_win_errs = 0;
            m_lock_bits++;
            if (err) m_win_errs++;
            m_bits = sat_inc(m_bits);
            if (err) m_errs = sat_inc(m_errs);
            if (m_win_errs == LOSS_ERRS) begin
                m_locked = 1'b0;
                m_run    = 0;
                hist.delete();
            end
        end
        while (hist.size() > 8) void'(hist.pop_front());
        if (clr) begin
            m_errs = '0;
            m_bits = '0;
        end
        e.locked    = m_locked;
        e.err_pulse = err;
        e.errs      = m_errs;
        e.bits      = m_bits;
        sb.push_back(e);
    endfunction

    // Registered view of which edges carried a strobe
    logic en_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_d <= 1'b0;
        else        en_d <= bit_en;
    end

    // Monitor: pop on strobe-driven cycles, otherwise outputs must hold
    obs_t last;
    always @(negedge clk) begin : monitor
        obs_t e;
        if (!rst_n) begin
            last = '{default: '0};
        end else if (en_d) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: actual 0 required 1 queued entries (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("mon_locked",    locked,    e.locked);
                check("mon_err_pulse", err_pulse, e.err_pulse);
                check("mon_err_count", err_count, e.errs);
                check("mon_bit_count", bit_count, e.bits);
                last           = e;
                last.err_pulse = 1'b0;
            end
        end else begin
            check("hold_locked",    locked,    last.locked);
            check("hold_err_pulse", err_pulse, 1'b0);
            check("hold_err_count", err_count, last.errs);
            check("hold_bit_count", bit_count, last.bits);
        end
    end

    // One strobe every 4th clock, line randomized while bit_en is low
    task automatic send(input logic b, input logic clr);
        @(posedge clk); #2;
        bit_en  = 1'b1;
        prbs_in = b;
        clear   = clr;
        model_step(b, clr);
        @(posedge clk); #2;
        bit_en  = 1'b0;
        clear   = 1'b0;
        prbs_in = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(gen_next(), 1'b0);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic b;
        bit_en  = 1'b0;
        clear   = 1'b0;
        prbs_in = 1'b0;
        rst_n   = 1'b0;
        gen_s   = 8'hFF;
        model_reset();

        #12;
        check("rst_locked",    locked,    1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_count", err_count, '0);
        check("rst_bit_count", bit_count, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Clean stream: lock on the 24th strobe, then 976 error-free bits
        for (int i = 1; i <= 1000; i++) begin
            send(gen_next(), 1'b0);
            if (i == 23) check("lock_after_23", locked, 1'b0);
            if (i == 24) check("lock_after_24", locked, 1'b1);
        end
        check("clean_err_count", err_count, 0);
        check("clean_bit_count", bit_count, 976);

        // Single line error while locked is counted exactly once
        send(!gen_next(), 1'b0);
        check("flip_err_count", err_count, 1);
        check("flip_locked",    locked,    1'b1);
        send_clean(100);
        check("flip_after_errs",   err_count, 1);
        check("flip_after_locked", locked,    1'b1);

        // bit_en low for 50 clocks while the line toggles randomly
        repeat (50) begin
            @(posedge clk); #2;
            prbs_in = 1'($urandom_range(0, 1));
        end
        check("gate_locked",    locked,    m_locked);
        check("gate_err_count", err_count, m_errs);
        check("gate_bit_count", bit_count, m_bits);

        // clear coincident with an error
        send(!gen_next(), 1'b1);
        check("clear_err_count", err_count, 0);
        check("clear_bit_count", bit_count, 0);
        check("clear_locked",    locked,    1'b1);

        // Random sparse errors and occasional clears
        for (int i = 0; i < 300; i++) begin
            b = gen_next();
            send(($urandom_range(0, 49) == 0) ? !b : b, ($urandom_range(0, 99) == 0));
        end

        // Loss of lock: 8 errors on alternate bits inside one window
        do_reset();
        send_clean(24);
        check("loss_prelock", locked, 1'b1);
        send_clean(10);
        for (int k = 0; k < 15; k++) begin
            b = gen_next();
            send((k % 2 == 0) ? !b : b, 1'b0);
            if (k == 13) check("loss_before_8th", locked, 1'b1);
        end
        check("loss_locked",    locked,    1'b0);
        check("loss_err_count", err_count, 8);
        send_clean(23);
        check("relock_23", locked, 1'b0);
        send_clean(1);
        check("relock_24",        locked,    1'b1);
        check("relock_err_count", err_count, 8);

        // Asynchronous reset while locked with nonzero counts
        send_clean(10);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_locked",    locked,    1'b0);
        check("arst_err_pulse", err_pulse, 1'b0);
        check("arst_err_count", err_count, 0);
        check("arst_bit_count", bit_count, 0);
        model_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_clean(23);
        check("arst_relock_23", locked, 1'b0);
        send_clean(1);
        check("arst_relock_24", locked,    1'b1);
        check("arst_bits",      bit_count, 0);

        // Stuck-at-0 line
        do_reset();
        for (int i = 0; i < 500; i++) send(1'b0, 1'b0);
        check("stuck0_locked",    locked,    1'b0);
        check("stuck0_err_count", err_count, 0);
        check("stuck0_bit_count", bit_count, 0);

        // Stuck-at-1 line
        do_reset();
        for (int i = 0; i < 500; i++) send(1'b1, 1'b0);
        check("stuck1_locked",    locked,    1'b0);
        check("stuck1_bit_count", bit_count, 0);

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
